// File: rtl/inside_range_matcher_if.sv
// Load, query and result handshake bundle for inside_range_matcher.
// The master side drives table loads and queries; the slave side is the matcher.
interface inside_range_matcher_if #(
    parameter int WIDTH   = 4,
    parameter int ENTRIES = 4
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic             ld_valid;
    logic             ld_ready;
    logic [IW-1:0]    ld_idx;
    logic             ld_kind;
    logic             ld_signed;
    logic [WIDTH-1:0] ld_lo;
    logic [WIDTH-1:0] ld_hi;
    logic [WIDTH-1:0] ld_mask;
    logic             clr;
    logic             q_valid;
    logic             q_ready;
    logic [WIDTH-1:0] q_data;
    logic             q_signed;
    logic             r_valid;
    logic             r_ready;
    logic             r_match;
    logic [IW-1:0]    r_index;

    modport master (
        output ld_valid, ld_idx, ld_kind, ld_signed, ld_lo, ld_hi, ld_mask, clr,
        output q_valid, q_data, q_signed, r_ready,
        input  ld_ready, q_ready, r_valid, r_match, r_index
    );

    modport slave (
        input  ld_valid, ld_idx, ld_kind, ld_signed, ld_lo, ld_hi, ld_mask, clr,
        input  q_valid, q_data, q_signed, r_ready,
        output ld_ready, q_ready, r_valid, r_match, r_index
    );
endinterface

// File: rtl/inside_range_matcher.sv
// Sequential value/range membership table: scans one entry per cycle, reports lowest hit.
// Optional INSIDE_MATCHER_WILDCARD_EN adds per-entry don't-care masks for value entries.
module inside_range_matcher #(
    parameter int WIDTH   = 4,
    parameter int ENTRIES = 4
) (
    input logic clk,
    input logic rst_n,
    inside_range_matcher_if.slave bus
);
    localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state, state_next;

    logic [ENTRIES-1:0] ent_valid;
    logic [ENTRIES-1:0] ent_kind;
    logic [ENTRIES-1:0] ent_signed;
    logic [WIDTH-1:0]   ent_lo [ENTRIES];
    logic [WIDTH-1:0]   ent_hi [ENTRIES];
`ifdef INSIDE_MATCHER_WILDCARD_EN
    logic [WIDTH-1:0]   ent_mask [ENTRIES];
`else
    logic               unused_mask;
    assign unused_mask = ^bus.ld_mask;
`endif

    logic [WIDTH-1:0] q_data_r;
    logic             q_signed_r;
    logic [IW-1:0]    scan_idx;
    logic             found;
    logic [IW-1:0]    found_idx;

    logic             accept;
    logic             wr_en;
    logic             idx_ok;
    logic             use_signed;
    logic             lo_ok;
    logic             hi_ok;
    logic             eq;
    logic             hit;
    logic [WIDTH-1:0] lo_v;
    logic [WIDTH-1:0] hi_v;

    assign wr_en  = (state == IDLE);
    assign accept = wr_en & bus.q_valid;
    assign idx_ok = ({1'b0, bus.ld_idx} < (IW+1)'(ENTRIES));

    // clr then load in one block: the later NBA to the loaded bit wins, so it stays valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_valid <= '0;
        end else if (wr_en) begin
            if (bus.clr) ent_valid <= '0;
            if (bus.ld_valid && idx_ok) ent_valid[bus.ld_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && bus.ld_valid && idx_ok) begin
            ent_kind[bus.ld_idx]   <= bus.ld_kind;
            ent_signed[bus.ld_idx] <= bus.ld_signed;
            ent_lo[bus.ld_idx]     <= bus.ld_lo;
            ent_hi[bus.ld_idx]     <= bus.ld_hi;
`ifdef INSIDE_MATCHER_WILDCARD_EN
            ent_mask[bus.ld_idx]   <= bus.ld_mask;
`endif
        end
    end

    always_comb begin
        lo_v       = ent_lo[scan_idx];
        hi_v       = ent_hi[scan_idx];
        use_signed = q_signed_r & ent_signed[scan_idx];
        if (use_signed) begin
            lo_ok = $signed(lo_v) <= $signed(q_data_r);
            hi_ok = $signed(q_data_r) <= $signed(hi_v);
        end else begin
            lo_ok = lo_v <= q_data_r;
            hi_ok = q_data_r <= hi_v;
        end
`ifdef INSIDE_MATCHER_WILDCARD_EN
        eq = ((q_data_r ^ lo_v) & ~ent_mask[scan_idx]) == '0;
`else
        eq = (q_data_r == lo_v);
`endif
        hit = ent_valid[scan_idx] & (ent_kind[scan_idx] ? (lo_ok & hi_ok) : eq);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_data_r   <= '0;
            q_signed_r <= 1'b0;
            scan_idx   <= '0;
            found      <= 1'b0;
            found_idx  <= '0;
        end else if (accept) begin
            q_data_r   <= bus.q_data;
            q_signed_r <= bus.q_signed;
            scan_idx   <= '0;
            found      <= 1'b0;
            found_idx  <= '0;
        end else if (state == SCAN) begin
            scan_idx <= scan_idx + 1'b1;
            if (hit && !found) begin
                found     <= 1'b1;
                found_idx <= scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        bus.ld_ready = 1'b0;
        bus.q_ready  = 1'b0;
        bus.r_valid  = 1'b0;
        bus.r_match  = 1'b0;
        bus.r_index  = '0;
        case (state)
            IDLE: begin
                bus.ld_ready = 1'b1;
                bus.q_ready  = 1'b1;
                if (bus.q_valid) state_next = SCAN;
            end
            SCAN: begin
                if (scan_idx == IW'(ENTRIES - 1)) state_next = DONE;
            end
            DONE: begin
                bus.r_valid = 1'b1;
                bus.r_match = found;
                bus.r_index = found_idx;
                if (bus.r_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule
